// File: rtl/breadboard_sweep_ctrl.sv
// breadboard_sweep_ctrl
// Sweeps the 4-bit w/x/y/z drive of the breadboard block from FIRST to LAST
// (wrapping 15->0), waits SETTLE cycles per step, captures the 10-bit r row,
// offers it to a logger over valid/ready and folds it into a rotating XOR
// signature.
// Optional build macro STEP_MODE_EN: adds a 'step' input and a HOLD state so
// that each non-final step waits for an explicit step pulse before advancing.
module breadboard_sweep_ctrl #(
    parameter int FIRST  = 0,   // first sweep index, 0..15
    parameter int LAST   = 15,  // last sweep index, 0..15
    parameter int SETTLE = 2    // settle cycles per step, 1..15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
`ifdef STEP_MODE_EN
    input  logic       step,
`endif
    output logic       w,
    output logic       x,
    output logic       y,
    output logic       z,
    input  logic [9:0] r,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_idx,
    output logic [9:0] res_data,
    output logic       busy,
    output logic       done,
    output logic [9:0] sig
);

    localparam logic [3:0] FIRST_IDX = 4'(FIRST);
    localparam logic [3:0] LAST_IDX  = 4'(LAST);
    localparam logic [3:0] CNT_INIT  = 4'(SETTLE - 1);

`ifdef STEP_MODE_EN
    typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_PRESENT, S_DONE, S_HOLD} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_PRESENT, S_DONE} state_t;
`endif

    state_t     state;
    state_t     state_next;
    logic [3:0] idx;
    logic [3:0] cnt;

    // Control strobes produced by the next-state logic for the datapath.
    logic start_sweep;
    logic dec_cnt;
    logic capture;
    logic accept;
    logic advance;
    logic cancel;
    logic finish;

    // Drive pins follow the registered index, so they move only when idx does.
    assign {w, x, y, z} = idx;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state decode and per-cycle control strobes; abort outranks a handshake.
    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path through the case leaves a signal unassigned (no latches).
        state_next  = state;
        start_sweep = 1'b0;
        dec_cnt     = 1'b0;
        capture     = 1'b0;
        accept      = 1'b0;
        advance     = 1'b0;
        cancel      = 1'b0;
        finish      = 1'b0;
        done        = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    start_sweep = 1'b1;
                    state_next  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    cancel     = 1'b1;
                    state_next = S_IDLE;
                end else if (cnt == 4'd0) begin
                    capture    = 1'b1;
                    state_next = S_PRESENT;
                end else begin
                    dec_cnt = 1'b1;
                end
            end
            S_PRESENT: begin
                if (abort) begin
                    cancel     = 1'b1;
                    state_next = S_IDLE;
                end else if (res_ready) begin
                    accept = 1'b1;
                    if (idx == LAST_IDX) begin
                        state_next = S_DONE;
                    end else begin
`ifdef STEP_MODE_EN
                        state_next = S_HOLD;
`else
                        advance    = 1'b1;
                        state_next = S_SETTLE;
`endif
                    end
                end
            end
`ifdef STEP_MODE_EN
            S_HOLD: begin
                if (abort) begin
                    cancel     = 1'b1;
                    state_next = S_IDLE;
                end else if (step) begin
                    advance    = 1'b1;
                    state_next = S_SETTLE;
                end
            end
`endif
            S_DONE: begin
                done       = 1'b1;
                finish     = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: index, settle counter, captured row, signature and busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= 4'd0;
            cnt       <= 4'd0;
            res_valid <= 1'b0;
            res_idx   <= 4'd0;
            res_data  <= 10'd0;
            sig       <= 10'd0;
            busy      <= 1'b0;
        end else begin
            if (start_sweep) begin
                idx  <= FIRST_IDX;
                cnt  <= CNT_INIT;
                sig  <= 10'd0;
                busy <= 1'b1;
            end
            if (dec_cnt) begin
                cnt <= cnt - 4'd1;
            end
            if (capture) begin
                res_data  <= r;
                res_idx   <= idx;
                sig       <= {sig[8:0], sig[9]} ^ r;
                res_valid <= 1'b1;
            end
            if (accept) begin
                res_valid <= 1'b0;
            end
            if (advance) begin
                idx <= idx + 4'd1;
                cnt <= CNT_INIT;
            end
            if (cancel) begin
                res_valid <= 1'b0;
                busy      <= 1'b0;
            end
            if (finish) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_breadboard_sweep_ctrl.sv
// Bench for breadboard_sweep_ctrl: two instances (full 0..15 sweep, and a
// wrapping 14..1 sweep with a longer settle), rows scored through queues.
module tb_breadboard_sweep_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start0, abort0, res_ready0;
    logic       w0, x0, y0, z0, res_valid0, busy0, done0;
    logic [9:0] r0, res_data0, sig0;
    logic [3:0] res_idx0;
    logic       start1, abort1, res_ready1;
    logic       w1, x1, y1, z1, res_valid1, busy1, done1;
    logic [9:0] r1, res_data1, sig1;
    logic [3:0] res_idx1;

    typedef struct packed {
        logic [3:0] idx;
        logic [9:0] data;
    } row_t;

    row_t q0[$];
    row_t q1[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt0 = 0;
    int   done_cnt1 = 0;
    int   mode0 = 0;   // 0: r stuck at 001, 1: r stuck at 3FF, 2: breadboard model

    breadboard_sweep_ctrl dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0),
        .w(w0), .x(x0), .y(y0), .z(z0), .r(r0),
        .res_valid(res_valid0), .res_ready(res_ready0), .res_idx(res_idx0),
        .res_data(res_data0), .busy(busy0), .done(done0), .sig(sig0)
    );

    breadboard_sweep_ctrl #(.FIRST(14), .LAST(1), .SETTLE(3)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1),
        .w(w1), .x(x1), .y(y1), .z(z1), .r(r1),
        .res_valid(res_valid1), .res_ready(res_ready1), .res_idx(res_idx1),
        .res_data(res_data1), .busy(busy1), .done(done1), .sig(sig1)
    );

    // Stand-in for the breadboard: r4/r8 = y&z (high only at 3,7,11,15),
    // r5 high only at index 0, r3 low only at index 0.
    function automatic logic [9:0] bb(input logic [3:0] i);
        logic [9:0] v;
        v[0] = i[0];
        v[1] = i[1];
        v[2] = i[2] ^ i[3];
        v[3] = |i;
        v[4] = i[1] & i[0];
        v[5] = (i == 4'd0);
        v[6] = i[3];
        v[7] = ~i[2];
        v[8] = i[1] & i[0];
        v[9] = i[3] & ~i[0];
        return v;
    endfunction

    function automatic logic [9:0] r_of(input int mode, input logic [3:0] i);
        if (mode == 0) return 10'h001;
        if (mode == 1) return 10'h3FF;
        return bb(i);
    endfunction

    function automatic logic [9:0] fold(input logic [9:0] s, input logic [9:0] d);
        return {s[8:0], s[9]} ^ d;
    endfunction

    always_comb r0 = r_of(mode0, {w0, x0, y0, z0});
    always_comb r1 = bb({w1, x1, y1, z1});

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Queue the rows a complete sweep must produce and return its final signature.
    task automatic push_range(input int first, input int last, input int mode,
                              input int which, output logic [9:0] s);
        int   i;
        row_t rw;
        s = 10'd0;
        i = first;
        while (1) begin
            rw.idx  = 4'(i);
            rw.data = r_of(mode, 4'(i));
            if (which == 0) q0.push_back(rw);
            else            q1.push_back(rw);
            s = fold(s, rw.data);
            if (i == last) break;
            i = (i + 1) % 16;
        end
    endtask

    task automatic wait_done0(output int n);
        n = 0;
        while (!done0 && n < 2000) begin
            cyc();
            n++;
        end
        check("dut0_done_seen", done0, 1);
    endtask

    task automatic wait_done1(output int n);
        n = 0;
        while (!done1 && n < 2000) begin
            cyc();
            n++;
        end
        check("dut1_done_seen", done1, 1);
    endtask

    // Scoreboard for dut0: a handshake is pending when valid&ready hold with no abort/reset.
    always @(negedge clk) begin
        if (!rst && !abort0 && res_valid0 && res_ready0) begin
            check("dut0_row_expected", q0.size() != 0, 1);
            if (q0.size() != 0) begin
                row_t e;
                e = q0.pop_front();
                check("dut0_res_idx", res_idx0, e.idx);
                check("dut0_res_data", res_data0, e.data);
                if (mode0 == 2) begin
                    check("dut0_r4", res_data0[4], res_idx0[1:0] == 2'b11);
                    check("dut0_r8", res_data0[8], res_idx0[1:0] == 2'b11);
                    if (res_idx0 == 4'd0) begin
                        check("dut0_r5_idx0", res_data0[5], 1);
                        check("dut0_r3_idx0", res_data0[3], 0);
                    end
                end
            end
        end
        if (done0) done_cnt0++;
    end

    // Scoreboard for dut1.
    always @(negedge clk) begin
        if (!rst && !abort1 && res_valid1 && res_ready1) begin
            check("dut1_row_expected", q1.size() != 0, 1);
            if (q1.size() != 0) begin
                row_t e;
                e = q1.pop_front();
                check("dut1_res_idx", res_idx1, e.idx);
                check("dut1_res_data", res_data1, e.data);
            end
        end
        if (done1) done_cnt1++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] es;
        int         n;
        int         dc;
        int         k;
        rst = 1'b1;
        start0 = 1'b0; abort0 = 1'b0; res_ready0 = 1'b1;
        start1 = 1'b0; abort1 = 1'b0; res_ready1 = 1'b1;
        mode0 = 0;
        cyc();
        cyc();
        check("rst_wxyz0", {w0, x0, y0, z0}, 0);
        check("rst_valid0", res_valid0, 0);
        check("rst_idx0", res_idx0, 0);
        check("rst_data0", res_data0, 0);
        check("rst_busy0", busy0, 0);
        check("rst_done0", done0, 0);
        check("rst_sig0", sig0, 0);
        check("rst_busy1", busy1, 0);
        check("rst_valid1", res_valid1, 0);
        rst = 1'b0;
        cyc();

        // Full sweep, r stuck at 001, ready always high: order, signature, latency.
        mode0 = 0;
        push_range(0, 15, 0, 0, es);
        dc = done_cnt0;
        start0 = 1'b1;
        cyc();
        start0 = 1'b0;
        check("sweep1_busy", busy0, 1);
        wait_done0(n);
        check("sweep1_latency", n, 48);
        check("sweep1_sig", sig0, 10'h3C0);
        cyc();
        check("sweep1_done_one_cycle", done0, 0);
        check("sweep1_busy_low", busy0, 0);
        check("sweep1_done_count", done_cnt0 - dc, 1);
        check("sweep1_rows_left", q0.size(), 0);
        cyc();
        check("sweep1_sig_hold", sig0, 10'h3C0);

        // Full sweep, r stuck at 3FF.
        mode0 = 1;
        push_range(0, 15, 1, 0, es);
        start0 = 1'b1;
        cyc();
        start0 = 1'b0;
        wait_done0(n);
        check("sweep2_sig", sig0, 10'h000);
        cyc();
        check("sweep2_rows_left", q0.size(), 0);

        // Breadboard model, logger stalls 5 cycles on row 6.
        mode0 = 2;
        push_range(0, 15, 2, 0, es);
        start0 = 1'b1;
        cyc();
        start0 = 1'b0;
        n = 0;
        while (!({w0, x0, y0, z0} == 4'd6 && !res_valid0) && n < 200) begin
            cyc();
            n++;
        end
        check("stall_reached_idx6", {w0, x0, y0, z0}, 6);
        res_ready0 = 1'b0;
        n = 0;
        while (!res_valid0 && n < 200) begin
            cyc();
            n++;
        end
        check("stall_valid_up", res_valid0, 1);
        for (k = 0; k < 5; k++) begin
            check("stall_valid_hold", res_valid0, 1);
            check("stall_idx_hold", res_idx0, 6);
            check("stall_data_hold", res_data0, bb(4'd6));
            check("stall_wxyz_hold", {w0, x0, y0, z0}, 4'b0110);
            cyc();
        end
        check("stall_valid_after", res_valid0, 1);
        res_ready0 = 1'b1;
        wait_done0(n);
        check("sweep3_sig", sig0, es);
        cyc();
        check("sweep3_rows_left", q0.size(), 0);

        // Reset while a row is presented, then a normal sweep.
        res_ready0 = 1'b0;
        start0 = 1'b1;
        cyc();
        start0 = 1'b0;
        n = 0;
        while (!res_valid0 && n < 200) begin
            cyc();
            n++;
        end
        check("rstmid_present", res_valid0, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("rstmid_wxyz", {w0, x0, y0, z0}, 0);
        check("rstmid_valid", res_valid0, 0);
        check("rstmid_idx", res_idx0, 0);
        check("rstmid_data", res_data0, 0);
        check("rstmid_busy", busy0, 0);
        check("rstmid_done", done0, 0);
        check("rstmid_sig", sig0, 0);
        res_ready0 = 1'b1;
        push_range(0, 15, 2, 0, es);
        start0 = 1'b1;
        cyc();
        start0 = 1'b0;
        check("rstmid_restart_busy", busy0, 1);
        wait_done0(n);
        check("rstmid_restart_latency", n, 48);
        check("rstmid_restart_sig", sig0, es);
        cyc();
        check("rstmid_rows_left", q0.size(), 0);

        // Wrapping sweep 14,15,0,1 with SETTLE=3 (4 cycles per step).
        push_range(14, 1, 2, 1, es);
        dc = done_cnt1;
        start1 = 1'b1;
        cyc();
        start1 = 1'b0;
        wait_done1(n);
        check("wrap_latency", n, 16);
        check("wrap_sig", sig1, es);
        cyc();
        check("wrap_done_count", done_cnt1 - dc, 1);
        check("wrap_rows_left", q1.size(), 0);

        // Abort in the second SETTLE: one row delivered, no done, partial sig kept.
        push_range(14, 14, 2, 1, es);
        dc = done_cnt1;
        start1 = 1'b1;
        cyc();
        start1 = 1'b0;
        n = 0;
        while (!res_valid1 && n < 200) begin
            cyc();
            n++;
        end
        check("abort_first_row", res_valid1, 1);
        cyc();
        check("abort_in_settle", res_valid1, 0);
        check("abort_wxyz_pre", {w1, x1, y1, z1}, 15);
        abort1 = 1'b1;
        cyc();
        abort1 = 1'b0;
        check("abort_busy", busy1, 0);
        check("abort_valid", res_valid1, 0);
        check("abort_done", done1, 0);
        check("abort_sig", sig1, es);
        check("abort_wxyz_kept", {w1, x1, y1, z1}, 15);
        repeat (6) cyc();
        check("abort_no_done", done_cnt1 - dc, 0);
        check("abort_still_idle", busy1, 0);
        check("abort_rows_left", q1.size(), 0);

        // start and abort together in IDLE: start wins; abort then cancels.
        start1 = 1'b1;
        abort1 = 1'b1;
        cyc();
        start1 = 1'b0;
        check("start_beats_abort", busy1, 1);
        check("start_clears_sig", sig1, 0);
        cyc();
        abort1 = 1'b0;
        check("abort_after_start", busy1, 0);
        check("abort_after_start_done", done1, 0);
        repeat (3) cyc();
        check("final_rows_left0", q0.size(), 0);
        check("final_rows_left1", q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
